// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed seven-segment driver with frame-coherent shadows,
// leading-zero blanking, per-digit enable, decimal points and PWM brightness.
module seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int DIM_BITS    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    blank_lz,
    input  logic [DIM_BITS-1:0]     brightness,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    logic [CW-1:0]           div_cnt_q, div_cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    load_pending_q;
    logic [4*NUM_DIGITS-1:0] value_q;
    logic [NUM_DIGITS-1:0]   dp_q, en_q, an_d;
    logic                    blank_lz_q, slot_end, wrap, blank, lit, dp_d;
    logic [3:0]              nib;
    logic [6:0]              seg_d;

    function automatic logic [6:0] decode(input logic [3:0] h);
        case (h)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0010000;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b0000011;
            4'hC: decode = 7'b0100111;
            4'hD: decode = 7'b0100001;
            4'hE: decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        slot_end  = div_cnt_q == CW'(REFRESH_DIV - 1);
        wrap      = slot_end && idx_q == IW'(NUM_DIGITS - 1);
        div_cnt_d = slot_end ? '0 : div_cnt_q + CW'(1);
        idx_d     = wrap ? '0 : slot_end ? idx_q + IW'(1) : idx_q;
        nib       = value_q[4*idx_q +: 4];
        // shifting out the lower nibbles leaves zero only if this and every higher nibble is zero
        blank     = blank_lz_q && idx_q != '0 && (value_q >> (4*idx_q)) == '0;
        lit       = en_q[idx_q] && !blank && div_cnt_q != '0 && div_cnt_q[DIM_BITS-1:0] <= brightness;
        an_d      = lit ? ~(NUM_DIGITS'(1) << idx_q) : '1;
        seg_d     = lit ? decode(nib) : '1;
        dp_d      = lit ? ~dp_q[idx_q] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q      <= '0;
            idx_q          <= '0;
            load_pending_q <= 1'b1;
            value_q        <= '0;
            dp_q           <= '0;
            en_q           <= '0;
            blank_lz_q     <= 1'b0;
            an             <= '1;
            seg            <= '1;
            dp             <= 1'b1;
            frame_tick     <= 1'b0;
        end else begin
            div_cnt_q      <= div_cnt_d;
            idx_q          <= idx_d;
            load_pending_q <= 1'b0;
            if (load_pending_q || wrap) begin
                value_q    <= value;
                dp_q       <= dp_in;
                en_q       <= digit_en;
                blank_lz_q <= blank_lz;
            end
            an             <= an_d;
            seg            <= seg_d;
            dp             <= dp_d;
            frame_tick     <= wrap;
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: randomized and directed checks of seg_scan_driver (4 digits, 16-cycle slots,
// 3-bit dimming) against a cycle-index based reference model.
module tb_seg_scan_driver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = '0;
    logic        blank_lz = 1'b0;
    logic [2:0]  brightness = '0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110};
    logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // reference state: n counts cycles since reset release; frame = 64 cycles
    int          n = 0;
    logic [15:0] sh_v = '0;
    logic [3:0]  sh_en = '0;
    logic [3:0]  sh_dp = '0;
    logic        sh_blz = 1'b0;
    logic [11:0] exp_o = 12'hfff;
    logic        exp_tick = 1'b0;

    seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(16), .DIM_BITS(3)) dut (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .digit_en(digit_en),
        .blank_lz(blank_lz), .brightness(brightness), .seg(seg), .dp(dp), .an(an),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] model_out(input int cyc, input logic [15:0] v, input logic [3:0] en,
                                              input logic [3:0] dpv, input logic blz, input logic [2:0] br);
        int dv;
        int ix;
        logic blank;
        logic [3:0] oh;
        dv = cyc % 16;
        ix = (cyc / 16) % 4;
        blank = blz && ix != 0;
        for (int j = ix; j < 4; j++) if (v[4*j +: 4] != 4'h0) blank = 1'b0;
        oh = 4'b0001 << ix;
        if (en[ix] && !blank && dv != 0 && (dv % 8) <= int'(br)) return {~oh, seg_tab[v[4*ix +: 4]], ~dpv[ix]};
        return 12'hfff;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            n <= 0;
            sh_v <= '0;
            sh_en <= '0;
            sh_dp <= '0;
            sh_blz <= 1'b0;
            exp_o <= 12'hfff;
            exp_tick <= 1'b0;
        end else begin
            exp_o <= model_out(n, sh_v, sh_en, sh_dp, sh_blz, brightness);
            exp_tick <= (n % 64 == 63);
            if (n == 0 || n % 64 == 63) begin
                sh_v <= value;
                sh_en <= digit_en;
                sh_dp <= dp_in;
                sh_blz <= blank_lz;
            end
            n <= n + 1;
        end
    end

    task automatic wait_tick(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!frame_tick && cyc < 200);
        checks++;
        if (frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL tick_timeout: frame_tick=%b after %0d cycles, required 1", frame_tick, cyc);
        end
    endtask

    task automatic test_reset();
        int c;
        rst = 1'b1;
        value = 16'hBEEF;
        digit_en = 4'hF;
        brightness = 3'd7;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp, frame_tick} !== 13'h1FFE) begin
                errors++;
                $display("FAIL reset_state: got %h required 1ffe", {an, seg, dp, frame_tick});
            end
        end
        rst = 1'b0;
        wait_tick(c);
        checks++;
        if (c !== 64) begin
            errors++;
            $display("FAIL first_tick: got %0d cycles required 64", c);
        end
        wait_tick(c);
        checks++;
        if (c !== 64) begin
            errors++;
            $display("FAIL tick_period: got %0d cycles required 64", c);
        end
    endtask

    task automatic test_decode_scan();
        int c;
        int dv;
        int ix;
        logic [6:0] want [4] = '{7'b0001110, 7'b0100100, 7'b0001000, 7'b1111001};
        value = 16'h1A2F;
        brightness = 3'd7;
        digit_en = 4'hF;
        dp_in = 4'h0;
        blank_lz = 1'b0;
        wait_tick(c);
        for (int j = 1; j <= 64; j++) begin
            @(negedge clk);
            dv = (j - 1) % 16;
            ix = (j - 1) / 16;
            checks++;
            if ({an, seg, dp, frame_tick} !== {exp_o, exp_tick}) begin
                errors++;
                $display("FAIL model_scan: got %h required %h", {an, seg, dp, frame_tick}, {exp_o, exp_tick});
            end
            checks++;
            if (dv == 0 ? an !== 4'hF : (an !== an_tab[ix] || seg !== want[ix])) begin
                errors++;
                $display("FAIL scan_decode: div=%0d idx=%0d an=%b seg=%b required an=%b seg=%b",
                         dv, ix, an, seg, dv == 0 ? 4'hF : an_tab[ix], want[ix]);
            end
        end
    endtask

    task automatic test_blanking();
        int c;
        int lit0;
        int lit1;
        value = 16'h0050;
        blank_lz = 1'b1;
        digit_en = 4'hF;
        brightness = 3'd7;
        wait_tick(c);
        lit0 = 0;
        lit1 = 0;
        for (int j = 1; j <= 64; j++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp, frame_tick} !== {exp_o, exp_tick}) begin
                errors++;
                $display("FAIL model_blank: got %h required %h", {an, seg, dp, frame_tick}, {exp_o, exp_tick});
            end
            checks++;
            if (an === 4'b0111 || an === 4'b1011 || (an === 4'b1101 && seg !== 7'b0010010) ||
                (an === 4'b1110 && seg !== 7'b1000000)) begin
                errors++;
                $display("FAIL blank_0050: an=%b seg=%b", an, seg);
            end
            lit0 += int'(an === 4'b1110);
            lit1 += int'(an === 4'b1101);
        end
        checks++;
        if (lit0 != 15 || lit1 != 15) begin
            errors++;
            $display("FAIL blank_lit_count: digit0=%0d digit1=%0d required 15 and 15", lit0, lit1);
        end
        value = 16'h0000;
        wait_tick(c);
        lit0 = 0;
        for (int j = 1; j <= 64; j++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp, frame_tick} !== {exp_o, exp_tick}) begin
                errors++;
                $display("FAIL model_zero: got %h required %h", {an, seg, dp, frame_tick}, {exp_o, exp_tick});
            end
            checks++;
            if (an !== 4'hF && (an !== 4'b1110 || seg !== 7'b1000000)) begin
                errors++;
                $display("FAIL blank_zero: an=%b seg=%b required an=1110 seg=1000000 or unlit", an, seg);
            end
            lit0 += int'(an === 4'b1110);
        end
        checks++;
        if (lit0 != 15) begin
            errors++;
            $display("FAIL zero_lit_count: got %0d required 15", lit0);
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_frame_coherence();
        int c;
        int dv;
        int ix;
        logic [6:0] old_s [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        logic [6:0] new_s [4] = '{7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010};
        value = 16'h1234;
        wait_tick(c);
        for (int j = 1; j <= 128; j++) begin
            @(negedge clk);
            if (j == 24) value = 16'h5678;
            dv = (j - 1) % 16;
            ix = ((j - 1) / 16) % 4;
            checks++;
            if ({an, seg, dp, frame_tick} !== {exp_o, exp_tick}) begin
                errors++;
                $display("FAIL model_coherence: got %h required %h", {an, seg, dp, frame_tick}, {exp_o, exp_tick});
            end
            checks++;
            if (dv != 0 && seg !== (j > 64 ? new_s[ix] : old_s[ix])) begin
                errors++;
                $display("FAIL coherence: j=%0d idx=%0d seg=%b required %b", j, ix, seg,
                         j > 64 ? new_s[ix] : old_s[ix]);
            end
        end
    endtask

    task automatic test_pwm();
        int c;
        int dv;
        logic want;
        value = 16'($urandom);
        digit_en = 4'hF;
        for (int b = 0; b < 2; b++) begin
            brightness = b == 0 ? 3'd0 : 3'd3;
            wait_tick(c);
            for (int j = 1; j <= 64; j++) begin
                @(negedge clk);
                dv = (j - 1) % 16;
                want = b == 0 ? dv == 8 : ((dv % 8 >= 1 && dv % 8 <= 3) || (dv >= 8 && dv <= 11));
                checks++;
                if ({an, seg, dp, frame_tick} !== {exp_o, exp_tick}) begin
                    errors++;
                    $display("FAIL model_pwm: got %h required %h", {an, seg, dp, frame_tick}, {exp_o, exp_tick});
                end
                checks++;
                if ((an !== 4'hF) !== want) begin
                    errors++;
                    $display("FAIL pwm_gate: br=%0d div=%0d an=%b lit_required=%b", brightness, dv, an, want);
                end
            end
        end
    endtask

    task automatic test_enable_dp_reset();
        int c;
        value = 16'($urandom);
        brightness = 3'd7;
        digit_en = 4'b1011;
        dp_in = 4'b0100;
        wait_tick(c);
        for (int j = 1; j <= 64; j++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp, frame_tick} !== {exp_o, exp_tick}) begin
                errors++;
                $display("FAIL model_enable: got %h required %h", {an, seg, dp, frame_tick}, {exp_o, exp_tick});
            end
            checks++;
            if (an === 4'b1011 || dp !== 1'b1) begin
                errors++;
                $display("FAIL enable_dp: an=%b dp=%b required digit2 dark and dp=1", an, dp);
            end
        end
        dp_in = 4'b0010;
        wait_tick(c);
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp, frame_tick} !== {exp_o, exp_tick}) begin
                errors++;
                $display("FAIL model_dp: got %h required %h", {an, seg, dp, frame_tick}, {exp_o, exp_tick});
            end
            checks++;
            if ((dp === 1'b0) !== (an === 4'b1101)) begin
                errors++;
                $display("FAIL dp_select: an=%b dp=%b required dp=0 only with an=1101", an, dp);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({an, seg, dp, frame_tick} !== 13'h1FFE) begin
            errors++;
            $display("FAIL mid_reset: got %h required 1ffe", {an, seg, dp, frame_tick});
        end
        @(negedge clk);
        rst = 1'b0;
        wait_tick(c);
        checks++;
        if (c !== 64) begin
            errors++;
            $display("FAIL tick_after_reset: got %0d cycles required 64", c);
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 640; j++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp, frame_tick} !== {exp_o, exp_tick}) begin
                errors++;
                $display("FAIL model_random: cycle=%0d got %h required %h", j, {an, seg, dp, frame_tick},
                         {exp_o, exp_tick});
            end
            if ($urandom_range(7) == 0) value = 16'($urandom) & (($urandom_range(1) == 0) ? 16'h00FF : 16'hFFFF);
            if ($urandom_range(7) == 0) dp_in = 4'($urandom);
            if ($urandom_range(7) == 0) digit_en = 4'($urandom);
            if ($urandom_range(7) == 0) blank_lz = 1'($urandom);
            if ($urandom_range(15) == 0) brightness = 3'($urandom);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_decode_scan();
        test_blanking();
        test_frame_coherence();
        test_pwm();
        test_enable_dp_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
